// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and memory stages
//
// Purpose: arbitrates fetch (if_*) and data (dm_*) requests onto one memory
// port (mem_*). Runs one transaction at a time, returns read data to the owner
// with a one-cycle ack, and drives per-stage stall requests. Data has priority,
// but a streak limit guarantees fetch progress. A watchdog aborts hung
// transactions and sets a sticky err flag.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_ack)
//   if_rdata/if_ack                fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ack)
//   dm_rdata/dm_ack                load data and completion pulse
//   stall_if/stall_dm              combinational stall requests
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  memory port
//   err                            sticky watchdog-abort flag
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WDOG_MAX   = WW'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [WW-1:0]     wdog_q, wdog_d;

  // A request whose ack is visible this cycle is already served; it must not
  // be re-issued even though the requester still holds req.
  logic if_elig, dm_elig;
  assign if_elig = if_req & ~if_ack_q;
  assign dm_elig = dm_req & ~dm_ack_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;

    case (state_q)
      IDLE: begin
        if (dm_elig && !(if_elig && streak_q == STREAK_MAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wdog_d      = '0;
          // Reaching here with fetch waiting implies streak < max, so the
          // increment saturates naturally at STREAK_MAX.
          streak_d    = if_elig ? streak_q + SW'(1) : '0;
        end else if (if_elig) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          wdog_d     = '0;
          streak_d   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else if (wdog_q == WDOG_MAX) begin
          // Abort: release the owner with zero data so the pipeline moves on.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      streak_q    <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign stall_if  = if_elig;
  assign stall_dm  = dm_elig;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall_if, stall_dm;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 = none, 1 = fetch, 2 = data. "run" counts data
  // wins over a waiting fetch; "age" counts cycles spent waiting on memory.
  int          m_owner, m_age, m_run;
  logic        m_mem_req, m_mem_we, m_if_ack, m_dm_ack, m_err;
  logic [31:0] m_mem_addr, m_mem_wdata, m_if_rdata, m_dm_rdata;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_run = 0;
    m_mem_req = 0; m_mem_we = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    m_mem_addr = 0; m_mem_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
  endtask

  task automatic model_step();
    bit          fetch_wants, data_wants;
    logic [31:0] rd;
    fetch_wants = if_req && !m_if_ack;
    data_wants  = dm_req && !m_dm_ack;
    m_if_ack = 0;
    m_dm_ack = 0;
    if (m_owner == 0) begin
      if (data_wants && !(fetch_wants && m_run >= MAXS)) begin
        m_owner = 2; m_mem_we = dm_we; m_mem_addr = dm_addr; m_mem_wdata = dm_wdata;
        m_run = fetch_wants ? ((m_run + 1 > MAXS) ? MAXS : m_run + 1) : 0;
      end else if (fetch_wants) begin
        m_owner = 1; m_mem_we = 0; m_mem_addr = if_addr; m_run = 0;
      end
      m_mem_req = (m_owner != 0);
      m_age = 0;
    end else if (mem_ack || m_age >= TMO) begin
      rd = mem_ack ? mem_rdata : 32'h0;
      if (!mem_ack) m_err = 1;
      if (m_owner == 1) begin
        m_if_ack = 1; m_if_rdata = rd;
      end else begin
        m_dm_ack = 1;
        if (!mem_ack || !m_mem_we) m_dm_rdata = rd;
      end
      m_owner = 0;
      m_mem_req = 0;
    end else begin
      m_age++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic check_model();
    check("mem_req", mem_req, m_mem_req);
    check("mem_we", mem_we, m_mem_we);
    check("mem_addr", mem_addr, m_mem_addr);
    check("mem_wdata", mem_wdata, m_mem_wdata);
    check("if_ack", if_ack, m_if_ack);
    check("dm_ack", dm_ack, m_dm_ack);
    check("if_rdata", if_rdata, m_if_rdata);
    check("dm_rdata", dm_rdata, m_dm_rdata);
    check("err", err, m_err);
    check("stall_if", stall_if, if_req && !m_if_ack);
    check("stall_dm", stall_dm, dm_req && !m_dm_ack);
  endtask

  typedef struct {
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        x_mem_req, x_mem_we;
    logic [31:0] x_mem_addr, x_mem_wdata;
    logic        x_dm_ack;
    logic [31:0] x_dm_rdata;
    logic        x_stall_dm;
  } vec_t;

  vec_t vecs[9];

  int          n_req, n_ack, k, ack_cyc, mwait, lat;
  logic [31:0] ack_rd;
  bit          got;

  initial begin
    // Load L=0 at 0x10, then store at 0x20 with L=1 (stray rdata ignored).
    vecs[0] = '{1, 0, 32'h10, 32'h0,    0, 32'h0,        0, 0, 32'h0,  32'h0,    0, 32'h0,        1};
    vecs[1] = '{1, 0, 32'h10, 32'h0,    1, 32'hDEADBEEF, 1, 0, 32'h10, 32'h0,    0, 32'h0,        1};
    vecs[2] = '{1, 0, 32'h10, 32'h0,    0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 32'hDEADBEEF, 0};
    vecs[3] = '{0, 0, 32'h0,  32'h0,    0, 32'h0,        0, 0, 32'h0,  32'h0,    0, 32'hDEADBEEF, 0};
    vecs[4] = '{1, 1, 32'h20, 32'h1234, 0, 32'h0,        0, 0, 32'h0,  32'h0,    0, 32'hDEADBEEF, 1};
    vecs[5] = '{1, 1, 32'h20, 32'h1234, 0, 32'h0,        1, 1, 32'h20, 32'h1234, 0, 32'hDEADBEEF, 1};
    vecs[6] = '{1, 1, 32'h20, 32'h1234, 1, 32'hFFFFFFFF, 1, 1, 32'h20, 32'h1234, 0, 32'hDEADBEEF, 1};
    vecs[7] = '{1, 1, 32'h20, 32'h1234, 0, 32'h0,        0, 0, 32'h0,  32'h0,    1, 32'hDEADBEEF, 0};
    vecs[8] = '{0, 0, 32'h0,  32'h0,    0, 32'h0,        0, 0, 32'h0,  32'h0,    0, 32'hDEADBEEF, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_dm_ack", dm_ack, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst = 0;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
      @(negedge clk);
      check($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].x_mem_req);
      if (vecs[i].x_mem_req) begin
        check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].x_mem_we);
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].x_mem_addr);
        check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].x_mem_wdata);
      end
      check($sformatf("vec%0d_dm_ack", i), dm_ack, vecs[i].x_dm_ack);
      check($sformatf("vec%0d_dm_rdata", i), dm_rdata, vecs[i].x_dm_rdata);
      check($sformatf("vec%0d_stall_dm", i), stall_dm, vecs[i].x_stall_dm);
    end

    // Back-to-back fetch, requester holds if_req through ack cycles
    n_req = 0; n_ack = 0; k = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin if_req = 1; if_addr = 32'h100; end
      if (if_ack) if_addr = if_addr + 4;
      mem_ack = mem_req;
      mem_rdata = 32'hA000 + c;
      @(negedge clk);
      if (mem_req) begin
        check("fetch_addr", mem_addr, 32'h100 + 4 * k);
        k++;
        n_req++;
      end
      if (if_ack) n_ack++;
    end
    check("fetch_mem_req_count", n_req, 4);
    check("fetch_ack_count", n_ack, 4);
    check("fetch_last_rdata", if_rdata, 32'hA00A);
    @(posedge clk); #1 if_req = 0; mem_ack = 0;

    // Randomized traffic against the reference model
    mwait = 0; lat = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (if_ack || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        if_req = 0;
      end
      if (dm_ack || !dm_req) begin
        dm_req = ($urandom_range(0, 1) == 0); dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (mem_req) begin
        mem_ack = (mwait >= lat); mwait++;
      end else begin
        mwait = 0; lat = $urandom_range(0, 3);
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      mem_rdata = $urandom;
      @(negedge clk);
      check_model();
    end

    // Drain
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if_req = 0; dm_req = 0; mem_ack = mem_req;
    end
    @(posedge clk); #1 mem_ack = 0; dm_we = 0;
    @(negedge clk);
    check_model();

    // Watchdog abort: mem_ack never arrives
    n_req = 0; ack_cyc = -1; ack_rd = 32'hFFFF_FFFF;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      dm_req = (c <= 10); dm_addr = 32'h40;
      @(negedge clk);
      if (mem_req) n_req++;
      if (dm_ack) begin ack_cyc = c; ack_rd = dm_rdata; end
      check_model();
    end
    check("wdog_mem_req_cycles", n_req, TMO + 1);
    check("wdog_ack_cycle", ack_cyc, TMO + 2);
    check("wdog_rdata", ack_rd, 0);
    check("wdog_err_sticky", err, 1);

    // Reset in BUSY_D at L=3, then reissue
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    end
    @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    @(posedge clk); #1 rst = 1;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_dm_ack", dm_ack, 0);
    check("midrst_dm_rdata", dm_rdata, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1 rst = 0;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge clk); #1;
      check("rst_no_ack", dm_ack, 0);
      if (mem_req) begin
        got = 1; mem_ack = 1; mem_rdata = 32'h5A5A_0080;
        check("reissue_addr", mem_addr, 32'h80);
      end
    end
    check("reissue_seen", got, 1);
    @(posedge clk); #1;
    mem_ack = 0;
    check("reissue_dm_ack", dm_ack, 1);
    check("reissue_dm_rdata", dm_rdata, 32'h5A5A_0080);
    dm_req = 0;
    @(negedge clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
